one_time_pad: RTL and testbench

ONE_TIME_PAD -- requirements
Module: one_time_pad

---
 rtl/one_time_pad.sv | 83 ++++++++
 tb/tb_one_time_pad.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/one_time_pad.sv
// Registered one-time-pad encryptor: the key is tiled across the data word and XORed in.
// Define OTP_REUSE_CHECK_EN to build the key-reuse detector; otherwise key_reuse is tied to 0.
module one_time_pad #(
    parameter int N = 2,
    parameter int M = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [M-1:0] plaintext,
    input  logic [N-1:0] key,
    output logic         out_valid,
    output logic [M-1:0] ciphertext,
    output logic [M-1:0] decryptedtext,
    output logic         key_reuse
);

    // Key bit i mod N lands on data bit i; key bits at or above M never get used.
    function automatic logic [M-1:0] tile_pad(input logic [N-1:0] k);
        logic [M-1:0] p;
        p = '0;
        for (int i = 0; i < M; i++) begin
            p[i] = k[i % N];
        end
        return p;
    endfunction

    logic [M-1:0] pad_p0;
    logic [M-1:0] ct_p0;
    logic [M-1:0] dt_p0;

    always_comb begin
        pad_p0 = tile_pad(key);
        ct_p0  = plaintext ^ pad_p0;
        dt_p0  = ct_p0 ^ pad_p0;
    end

    // ---- stage p0 -> p1: results registered one cycle after the sample ----
    logic         vld_p1;
    logic [M-1:0] ct_p1;
    logic [M-1:0] dt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ct_p1  <= '0;
            dt_p1  <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                ct_p1 <= ct_p0;
                dt_p1 <= dt_p0;
            end
        end
    end

`ifdef OTP_REUSE_CHECK_EN
    logic [N-1:0] prev_key_p1;
    logic         hist_vld_p1;
    logic         reuse_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_key_p1 <= '0;
            hist_vld_p1 <= 1'b0;
            reuse_p1    <= 1'b0;
        end else if (in_valid) begin
            reuse_p1    <= hist_vld_p1 && (key == prev_key_p1);
            prev_key_p1 <= key;
            hist_vld_p1 <= 1'b1;
        end
    end

    assign key_reuse = reuse_p1;
`else
    assign key_reuse = 1'b0;
`endif

    assign out_valid     = vld_p1;
    assign ciphertext    = ct_p1;
    assign decryptedtext = dt_p1;

endmodule

// File: tb/tb_one_time_pad.sv
// Bench for one_time_pad: fixed vectors, corner sequences and random traffic against a model.
module tb_one_time_pad;

`ifdef OTP_REUSE_CHECK_EN
    localparam bit REUSE_EN = 1'b1;
`else
    localparam bit REUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] plaintext;
    logic [1:0] key;
    logic [3:0] key4;
    logic [7:0] key8;

    logic       ov, kr, ov4, kr4, ov8, kr8;
    logic [5:0] ct, dt, ct4, dt4, ct8, dt8;

    int checks = 0;
    int failures = 0;

    // model state
    logic       e_vld, e_reuse;
    logic [5:0] e_ct, e_dt, e_ct4, e_ct8;
    logic       h_vld;
    logic [1:0] h_key;

    always #5 clk = ~clk;

    one_time_pad #(.N(2), .M(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .plaintext(plaintext), .key(key),
        .out_valid(ov), .ciphertext(ct), .decryptedtext(dt), .key_reuse(kr));

    one_time_pad #(.N(4), .M(6)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .plaintext(plaintext), .key(key4),
        .out_valid(ov4), .ciphertext(ct4), .decryptedtext(dt4), .key_reuse(kr4));

    one_time_pad #(.N(8), .M(6)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .plaintext(plaintext), .key(key8),
        .out_valid(ov8), .ciphertext(ct8), .decryptedtext(dt8), .key_reuse(kr8));

    // Pad built by repeating the key as a whole word every n bits, then truncating to 6 bits.
    function automatic logic [5:0] pad_of(input int n, input logic [7:0] k);
        longint unsigned p = 0;
        longint unsigned kk = longint'(k) & ((64'd1 << n) - 1);
        for (int j = 0; j < 6; j += n) p = p | (kk << j);
        return p[5:0];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, {7'd0, ov}, {7'd0, e_vld});
        chk({tag, ".ciphertext"}, {2'd0, ct}, {2'd0, e_ct});
        chk({tag, ".decryptedtext"}, {2'd0, dt}, {2'd0, e_dt});
        chk({tag, ".key_reuse"}, {7'd0, kr}, {7'd0, e_reuse});
        chk({tag, ".n4.ciphertext"}, {2'd0, ct4}, {2'd0, e_ct4});
        chk({tag, ".n8.ciphertext"}, {2'd0, ct8}, {2'd0, e_ct8});
        chk({tag, ".n4.out_valid"}, {7'd0, ov4}, {7'd0, e_vld});
        chk({tag, ".n8.decryptedtext"}, {2'd0, dt8}, {2'd0, e_dt});
    endtask

    task automatic model_reset();
        e_vld = 0; e_reuse = 0; e_ct = 0; e_dt = 0; e_ct4 = 0; e_ct8 = 0;
        h_vld = 0; h_key = 0;
    endtask

    // Drive one cycle on the falling edge, advance the model, check just after the rising edge.
    task automatic step(input string tag, input logic iv, input logic [5:0] pt,
                        input logic [1:0] k, input logic [3:0] k4, input logic [7:0] k8);
        @(negedge clk);
        in_valid = iv; plaintext = pt; key = k; key4 = k4; key8 = k8;
        e_vld = iv;
        if (iv) begin
            e_ct    = pt ^ pad_of(2, {6'd0, k});
            e_dt    = pt;
            e_ct4   = pt ^ pad_of(4, {4'd0, k4});
            e_ct8   = pt ^ pad_of(8, k8);
            e_reuse = REUSE_EN && h_vld && (k == h_key);
            h_vld   = 1'b1;
            h_key   = k;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    typedef struct {
        logic [5:0] pt;
        logic [1:0] k;
        logic [5:0] exp_ct;
        logic       exp_reuse;
    } vec_t;

    vec_t vecs[7];
    logic [5:0] held_ct, held_dt;

    initial begin
        vecs[0] = '{6'b101010, 2'b01, 6'b111111, 1'b0};
        vecs[1] = '{6'b110011, 2'b00, 6'b110011, 1'b0};
        vecs[2] = '{6'b000000, 2'b11, 6'b111111, 1'b0};
        vecs[3] = '{6'b111111, 2'b10, 6'b010101, 1'b0};
        vecs[4] = '{6'b000000, 2'b10, 6'b101010, 1'b1};
        vecs[5] = '{6'b100001, 2'b10, 6'b001011, 1'b1};
        vecs[6] = '{6'b010101, 2'b01, 6'b000000, 1'b0};

        // reset with a sample pending: must be discarded
        rst_n = 1'b0; in_valid = 1'b1; plaintext = 6'h2a; key = 2'b01; key4 = 4'h5; key8 = 8'h55;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // fixed vectors, each pulse followed by an idle cycle
        for (int i = 0; i < 7; i++) begin
            step($sformatf("vec%0d", i), 1'b1, vecs[i].pt, vecs[i].k, 4'h0, 8'h00);
            chk($sformatf("vec%0d.ct_const", i), {2'd0, ct}, {2'd0, vecs[i].exp_ct});
            chk($sformatf("vec%0d.dt_const", i), {2'd0, dt}, {2'd0, vecs[i].pt});
            chk($sformatf("vec%0d.reuse_const", i), {7'd0, kr}, {7'd0, vecs[i].exp_reuse & REUSE_EN});
            step($sformatf("vec%0d_idle", i), 1'b0, 6'h00, 2'b00, 4'h0, 8'h00);
        end

        // N=4 tiling: key 1011 over 6 bits gives 11_1011
        step("n4_tile", 1'b1, 6'b000000, 2'b11, 4'b1011, 8'hff);
        chk("n4_tile.ct_const", {2'd0, ct4}, 8'b0011_1011);
        held_ct = ct; held_dt = dt;

        // outputs hold through 5 idle cycles
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold%0d", i), 1'b0, 6'($urandom), 2'($urandom), 4'($urandom), 8'($urandom));
            chk($sformatf("hold%0d.ct_const", i), {2'd0, ct}, {2'd0, held_ct});
            chk($sformatf("hold%0d.dt_const", i), {2'd0, dt}, {2'd0, held_dt});
        end

        // mid-stream reset between edges clears outputs at once
        step("pre_rst", 1'b1, 6'b011001, 2'b01, 4'h3, 8'h0f);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // key sequence 01,01,10 right after reset: reuse 0,1,0 when the check is built
        step("seq0", 1'b1, 6'b000111, 2'b01, 4'h1, 8'h01);
        chk("seq0.reuse_const", {7'd0, kr}, 8'd0);
        step("seq1", 1'b1, 6'b111000, 2'b01, 4'h1, 8'h01);
        chk("seq1.reuse_const", {7'd0, kr}, {7'd0, REUSE_EN});
        step("seq2", 1'b1, 6'b101101, 2'b10, 4'h2, 8'h02);
        chk("seq2.reuse_const", {7'd0, kr}, 8'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), 6'($urandom),
                 2'($urandom), 4'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
